// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine for the multicycle MIPS datapath.
// MULT uses radix-2 Booth with a 2*WIDTH+1-bit accumulator. DIV uses restoring
// division on operand magnitudes. Both run one iteration per clock for WIDTH
// clocks. HI/LO change only at commit. A DIV by zero completes in one edge
// with div_zero set and leaves HI/LO untouched.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    // Booth accumulator: {partial high word, multiplier/low word, q(-1)}.
    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_d;

    // Multiplicand for MULT, divisor magnitude for DIV.
    logic [WIDTH-1:0]   opnd_q;

    // Restoring-division partial remainder and the dividend/quotient shifter.
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   quo_d;
    logic               neg_quo_q;
    logic               neg_rem_q;

    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH:0]     booth_hi_ext;
    logic [WIDTH:0]     booth_m_ext;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic               last_iter;

    assign last_iter = (cnt_q == LAST_CNT);

    // Operand magnitudes for DIV; the most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    always_comb begin
        a_mag = A[WIDTH-1] ? ((~A) + ONE_W) : A;
        b_mag = B[WIDTH-1] ? ((~B) + ONE_W) : B;
    end

    // One Booth step. The add is done one bit wider than the high word so that
    // subtracting the most negative multiplicand cannot overflow; the extra
    // bit then becomes the arithmetic-shift sign.
    always_comb begin
        booth_hi_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        booth_m_ext  = {opnd_q[WIDTH-1], opnd_q};
        booth_sum    = booth_hi_ext;
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_hi_ext + booth_m_ext;
            2'b10:   booth_sum = booth_hi_ext - booth_m_ext;
            default: booth_sum = booth_hi_ext;
        endcase
        acc_d = {booth_sum, acc_q[WIDTH:1]};
    end

    // One restoring-division step: shift in the next dividend bit and keep the
    // difference only when it is non-negative.
    always_comb begin
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            rem_d = div_trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied at commit: quotient truncates toward zero and the
    // remainder follows the dividend's sign.
    always_comb begin
        quo_signed = neg_quo_q ? ((~quo_d) + ONE_W) : quo_d;
        rem_signed = neg_rem_q ? ((~rem_d) + ONE_W) : rem_d;
    end

    // Control FSM with registered outputs; HI/LO written only at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!op) begin
                            opnd_q  <= A;
                            acc_q   <= {{WIDTH{1'b0}}, B, 1'b0};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= MUL_RUN;
                        end else if (B != '0) begin
                            opnd_q    <= b_mag;
                            quo_q     <= a_mag;
                            rem_q     <= '0;
                            neg_quo_q <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_rem_q <= A[WIDTH-1];
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            state_q   <= DIV_RUN;
                        end else begin
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        hi_q    <= acc_d[2*WIDTH:WIDTH+1];
                        lo_q    <= acc_d[WIDTH:1];
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        hi_q    <= rem_signed;
                        lo_q    <= quo_signed;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: hand-computed MULT/DIV results,
// latency, divide-by-zero, overflow, ignored restarts, back-to-back issue and
// asynchronous reset mid-operation.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int passes = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op (caller is 1 ns after a rising edge) and waits up to 40
    // edges for done. Returns edges from start to done, busy just after the
    // start edge, and how many cycles busy was low while waiting.
    task automatic run_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                          output int lat, output logic busy0, output int busy_gaps);
        op    = op_v;
        A     = a_v;
        B     = b_v;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        busy0     = busy;
        lat       = 0;
        busy_gaps = 0;
        while (lat < 40 && !done) begin
            if (!busy) busy_gaps++;
            @(posedge clk); #1;
            lat++;
        end
        $display("op=%s A=%h B=%h -> HI=%h LO=%h div_zero=%b latency=%0d",
                 op_v ? "DIV " : "MULT", a_v, b_v, HI, LO, div_zero, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        else passes++;
        checks++;
        if ({HI, LO} !== 64'h0) $display("FAIL reset_hilo: got %h expected 0", {HI, LO});
        else passes++;
    endtask

    task automatic test_mult_basic();
        int lat; logic b0; int gaps;
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, lat, b0, gaps);
        checks++;
        if (lat !== 32) $display("FAIL mult_latency: got %0d expected 32", lat);
        else passes++;
        checks++;
        if (b0 !== 1'b1 || gaps !== 0) $display("FAIL mult_busy_window: got busy0=%b gaps=%0d expected 1/0", b0, gaps);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %b expected 0", busy);
        else passes++;
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) $display("FAIL mult_7x-3: got %h_%h expected ffffffff_ffffffeb", HI, LO);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b expected 0", done);
        else passes++;
    endtask

    task automatic test_div_signed();
        int lat; logic b0; int gaps;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, b0, gaps);
        checks++;
        if (lat !== 32) $display("FAIL div_latency: got %0d expected 32", lat);
        else passes++;
        checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) $display("FAIL div_-7/2: got %h_%h expected ffffffff_fffffffd", HI, LO);
        else passes++;
        run_op(1'b1, 32'd100, 32'd7, lat, b0, gaps);
        checks++;
        if (HI !== 32'd2 || LO !== 32'd14) $display("FAIL div_100/7: got %h_%h expected 00000002_0000000e", HI, LO);
        else passes++;
    endtask

    task automatic test_div_zero();
        int lat; logic b0; int gaps;
        // 0x692 / 0x20 leaves quotient 0x34, remainder 0x12.
        run_op(1'b1, 32'h692, 32'h20, lat, b0, gaps);
        checks++;
        if (HI !== 32'h12 || LO !== 32'h34) $display("FAIL div_preload: got %h_%h expected 00000012_00000034", HI, LO);
        else passes++;
        op    = 1'b1;
        A     = 32'd5;
        B     = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("op=DIV  A=%h B=%h -> HI=%h LO=%h div_zero=%b latency=0", 32'd5, 32'd0, HI, LO, div_zero);
        checks++;
        if ({done, div_zero, busy} !== 3'b110) $display("FAIL divzero_flags: got done,dz,busy=%b expected 110", {done, div_zero, busy});
        else passes++;
        checks++;
        if (HI !== 32'h12 || LO !== 32'h34) $display("FAIL divzero_hilo_hold: got %h_%h expected 00000012_00000034", HI, LO);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({done, div_zero, busy} !== 3'b000) $display("FAIL divzero_pulse_end: got %b expected 000", {done, div_zero, busy});
        else passes++;
    endtask

    task automatic test_overflow();
        int lat; logic b0; int gaps;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, b0, gaps);
        checks++;
        if (HI !== 32'h0 || LO !== 32'h8000_0000 || div_zero !== 1'b0)
            $display("FAIL div_overflow: got %h_%h dz=%b expected 00000000_80000000 dz=0", HI, LO, div_zero);
        else passes++;
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat, b0, gaps);
        checks++;
        if (HI !== 32'h4000_0000 || LO !== 32'h0) $display("FAIL mult_minneg_sq: got %h_%h expected 40000000_00000000", HI, LO);
        else passes++;
    endtask

    task automatic test_ignore_start();
        int cyc;
        op    = 1'b0;
        A     = 32'd3;
        B     = 32'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (cyc < 40 && !done) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5) begin
                start = 1'b1; op = 1'b1; A = 32'd100; B = 32'd7;
            end else if (cyc == 6) begin
                start = 1'b0; A = 32'hDEAD_BEEF; B = 32'd0;
            end
        end
        $display("op=MULT A=%h B=%h (restart ignored) -> HI=%h LO=%h latency=%0d", 32'd3, 32'd4, HI, LO, cyc);
        checks++;
        if (cyc !== 32) $display("FAIL ignore_latency: got %0d expected 32", cyc);
        else passes++;
        checks++;
        if (HI !== 32'h0 || LO !== 32'd12) $display("FAIL ignore_result: got %h_%h expected 00000000_0000000c", HI, LO);
        else passes++;
    endtask

    // Caller is in the done cycle of the previous op, so this issues back-to-back.
    task automatic test_back_to_back();
        int lat; logic b0; int gaps;
        run_op(1'b0, 32'hFFFF_FFFB, 32'd6, lat, b0, gaps);
        checks++;
        if (b0 !== 1'b1) $display("FAIL b2b_accepted: got busy=%b expected 1", b0);
        else passes++;
        checks++;
        if (lat !== 32 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFE2)
            $display("FAIL b2b_result: got lat=%0d %h_%h expected 32 ffffffff_ffffffe2", lat, HI, LO);
        else passes++;
    endtask

    task automatic test_async_reset();
        int lat; logic b0; int gaps; int done_seen;
        op    = 1'b1;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        $display("async reset mid-DIV -> busy=%b done=%b HI=%h LO=%h", busy, done, HI, LO);
        checks++;
        if ({busy, done, HI, LO} !== 66'h0) $display("FAIL async_reset_now: got busy=%b done=%b %h_%h expected all 0", busy, done, HI, LO);
        else passes++;
        @(posedge clk); #2;
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || busy !== 1'b0) $display("FAIL async_no_commit: got done_seen=%0d busy=%b expected 0/0", done_seen, busy);
        else passes++;
        run_op(1'b0, 32'd2, 32'd3, lat, b0, gaps);
        checks++;
        if (HI !== 32'h0 || LO !== 32'd6) $display("FAIL post_reset_mult: got %h_%h expected 00000000_00000006", HI, LO);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_div_signed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
